// File: rtl/order_gather_4.sv
// order_gather_4: packs a serial valid/ready word stream into groups of four
// parallel words for the order_1_4 sorter. Short groups closed by in_last are
// padded with PAD so padding sorts to the high end.
module order_gather_4 #(
  parameter int unsigned       DSIZE = 8,
  parameter logic [DSIZE-1:0]  PAD   = {DSIZE{1'b1}}
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] outdata0,
  output logic [DSIZE-1:0] outdata1,
  output logic [DSIZE-1:0] outdata2,
  output logic [DSIZE-1:0] outdata3,
  output logic [2:0]       out_count,
  output logic             out_last
);

  // Collect side: write index, slot buffer, and a held (pending) group.
  logic [1:0]       idx_q, idx_d;
  logic [DSIZE-1:0] coll_q [4];
  logic [DSIZE-1:0] coll_d [4];
  logic             pending_q, pending_d;
  logic [2:0]       pcount_q, pcount_d;
  logic             plast_q, plast_d;

  // Output registers.
  logic             ovalid_q, ovalid_d;
  logic [DSIZE-1:0] odata_q [4];
  logic [DSIZE-1:0] odata_d [4];
  logic [2:0]       ocount_q, ocount_d;
  logic             olast_q, olast_d;

  logic             accept;
  logic             closing;
  logic             out_free;
  logic             load_new;
  logic             load_pend;
  logic [DSIZE-1:0] group [4];
  logic [2:0]       group_count;

  // Handshake decode; in_ready depends on state only, never on in_valid.
  always_comb begin
    in_ready  = !pending_q && rst_n;
    accept    = in_valid && in_ready;
    closing   = accept && ((idx_q == 2'd3) || in_last);
    out_free  = !ovalid_q || out_ready;
    load_new  = closing && out_free;
    // No new word is accepted while pending, so the two loads never collide.
    load_pend = pending_q && out_free;
  end

  // Group as it would look if the current word closes it: earlier slots from
  // the buffer, this slot from in_data, later slots padded.
  always_comb begin
    group_count = {1'b0, idx_q} + 3'd1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (2'(i) < idx_q) begin
        group[i] = coll_q[i];
      end else if (2'(i) == idx_q) begin
        group[i] = in_data;
      end else begin
        group[i] = PAD;
      end
    end
  end

  // Collect next-state: write slots, close groups, hold a group when blocked.
  always_comb begin
    idx_d     = idx_q;
    coll_d    = coll_q;
    pending_d = pending_q;
    pcount_d  = pcount_q;
    plast_d   = plast_q;
    if (load_pend) begin
      pending_d = 1'b0;
    end
    if (accept) begin
      coll_d[idx_q] = in_data;
      idx_d         = idx_q + 2'd1;
    end
    if (closing) begin
      idx_d = 2'd0;
      if (!out_free) begin
        coll_d    = group;
        pending_d = 1'b1;
        pcount_d  = group_count;
        plast_d   = in_last;
      end
    end
  end

  // Output next-state: consume drops valid unless a group loads the same edge.
  always_comb begin
    ovalid_d = ovalid_q;
    odata_d  = odata_q;
    ocount_d = ocount_q;
    olast_d  = olast_q;
    if (ovalid_q && out_ready) begin
      ovalid_d = 1'b0;
    end
    if (load_new) begin
      ovalid_d = 1'b1;
      odata_d  = group;
      ocount_d = group_count;
      olast_d  = in_last;
    end else if (load_pend) begin
      ovalid_d = 1'b1;
      odata_d  = coll_q;
      ocount_d = pcount_q;
      olast_d  = plast_q;
    end
  end

  // State registers; reset discards any partial or pending group.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= 2'd0;
      pending_q <= 1'b0;
      pcount_q  <= 3'd0;
      plast_q   <= 1'b0;
      ovalid_q  <= 1'b0;
      ocount_q  <= 3'd0;
      olast_q   <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        coll_q[i]  <= '0;
        odata_q[i] <= '0;
      end
    end else begin
      idx_q     <= idx_d;
      pending_q <= pending_d;
      pcount_q  <= pcount_d;
      plast_q   <= plast_d;
      ovalid_q  <= ovalid_d;
      ocount_q  <= ocount_d;
      olast_q   <= olast_d;
      coll_q    <= coll_d;
      odata_q   <= odata_d;
    end
  end

  // Registered outputs only; no combinational path from in_* to out_*.
  always_comb begin
    out_valid = ovalid_q;
    outdata0  = odata_q[0];
    outdata1  = odata_q[1];
    outdata2  = odata_q[2];
    outdata3  = odata_q[3];
    out_count = ocount_q;
    out_last  = olast_q;
  end

endmodule

// File: tb/tb_order_gather_4.sv
// Bench for order_gather_4: table-driven frames plus hand-written sequences,
// all checked through a scoreboard queue popped when a group is consumed.
module tb_order_gather_4;

  logic       clock;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] outdata0, outdata1, outdata2, outdata3;
  logic [2:0] out_count;
  logic       out_last;

  order_gather_4 #(.DSIZE(8)) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .outdata0 (outdata0),
    .outdata1 (outdata1),
    .outdata2 (outdata2),
    .outdata3 (outdata3),
    .out_count(out_count),
    .out_last (out_last)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0][7:0] d;
    logic [2:0]      cnt;
    logic            lst;
  } grp_t;

  typedef struct packed {
    logic [2:0]      n;
    logic [3:0][7:0] w;
    logic            lst;
    logic [3:0][7:0] e;
    logic [2:0]      ecnt;
  } vec_t;

  grp_t       q[$];
  logic [7:0] part[$];
  int         total = 0;
  int         bad = 0;
  int         ngroups = 0;
  bit         use_model = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] n, input logic [7:0] w0, w1, w2, w3,
                              input logic lst, input logic [7:0] e0, e1, e2, e3,
                              input logic [2:0] ecnt);
    vec_t v;
    v.n = n;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    v.lst = lst;
    v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
    v.ecnt = ecnt;
    return v;
  endfunction

  // Scoreboard: compare each group at the edge where it is consumed.
  always @(negedge clock) begin
    if (rst_n && out_valid && out_ready) begin
      ngroups++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_group: got %0h,%0h,%0h,%0h expected none",
                 outdata0, outdata1, outdata2, outdata3);
      end else begin
        grp_t g;
        g = q.pop_front();
        chk("grp_data", {outdata3, outdata2, outdata1, outdata0}, g.d);
        chk("grp_count", out_count, g.cnt);
        chk("grp_last", out_last, g.lst);
      end
    end
  end

  // Drive one word from posedge+1 until accepted; optionally feed the model.
  task automatic send(input logic [7:0] d, input logic l, output int tries);
    bit acc;
    acc = 0;
    tries = 0;
    in_valid = 1;
    in_data = d;
    in_last = l;
    while (!acc && tries < 200) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
      tries++;
    end
    in_valid = 0;
    in_last = 0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no accept expected accept of %0h", d);
    end else if (use_model) begin
      part.push_back(d);
      if (l || part.size() == 4) begin
        grp_t g;
        for (int i = 0; i < 4; i++) g.d[i] = (i < part.size()) ? part[i] : 8'hFF;
        g.cnt = 3'(part.size());
        g.lst = l;
        q.push_back(g);
        part.delete();
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clock);
      n++;
    end
    #1;
    chk("drain", q.size(), 0);
  endtask

  initial begin
    vec_t tbl[4];
    int t, maxt, g0;
    logic [31:0] snap;

    clock = 0; rst_n = 0; in_valid = 0; in_data = 0; in_last = 0; out_ready = 1;
    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_data", {outdata3, outdata2, outdata1, outdata0}, 0);
    chk("rst_count", out_count, 0);
    chk("rst_last", out_last, 0);
    @(posedge clock); #1; rst_n = 1;
    @(posedge clock); #1;

    // Table frames: full group, partial flush, single word, last on 4th.
    tbl[0] = mk(4, 3, 7, 1, 9, 0, 3, 7, 1, 9, 4);
    tbl[1] = mk(2, 5, 2, 0, 0, 1, 5, 2, 8'hFF, 8'hFF, 2);
    tbl[2] = mk(1, 8'h42, 0, 0, 0, 1, 8'h42, 8'hFF, 8'hFF, 8'hFF, 1);
    tbl[3] = mk(4, 4, 3, 2, 1, 1, 4, 3, 2, 1, 4);
    use_model = 0;
    for (int k = 0; k < 4; k++) begin
      grp_t g;
      g.d = tbl[k].e;
      g.cnt = tbl[k].ecnt;
      g.lst = tbl[k].lst;
      q.push_back(g);
      for (int j = 0; j < int'(tbl[k].n); j++)
        send(tbl[k].w[j], tbl[k].lst && (j == int'(tbl[k].n) - 1), t);
      chk("latency_valid", out_valid, 1);
      @(posedge clock); #1;
      chk("one_cycle_valid", out_valid, 0);
      chk("tbl_consumed", q.size(), 0);
    end

    // in_last without in_valid is ignored.
    use_model = 1;
    send(20, 0, t);
    in_last = 1;
    @(posedge clock); #1;
    in_last = 0;
    send(21, 0, t); send(22, 0, t); send(23, 0, t);
    drain();

    // Backpressure: group 1 held, group 2 pending, in_ready low.
    out_ready = 0;
    for (int k = 0; k < 8; k++) send(8'(11 + k), 0, t);
    chk("bp_ready_low", in_ready, 0);
    snap = {outdata3, outdata2, outdata1, outdata0};
    repeat (3) @(posedge clock);
    #1;
    chk("bp_stable", {outdata3, outdata2, outdata1, outdata0}, snap);
    chk("bp_held_valid", out_valid, 1);
    chk("bp_still_blocked", in_ready, 0);
    out_ready = 1;
    @(posedge clock); #1;
    out_ready = 0;
    chk("bp_ready_back", in_ready, 1);
    chk("bp_g2_valid", out_valid, 1);
    chk("bp_g2_word", outdata0, 15);
    out_ready = 1;
    drain();

    // Streaming: one word per cycle, no stalls.
    g0 = ngroups;
    maxt = 0;
    for (int k = 0; k < 40; k++) begin
      send(8'($urandom_range(0, 10)), 0, t);
      if (t > maxt) maxt = t;
    end
    drain();
    chk("stream_no_stall", maxt, 1);
    chk("stream_groups", ngroups - g0, 10);

    // Reset mid-group with a held output group.
    out_ready = 0;
    for (int k = 0; k < 6; k++) send(8'(30 + k), 0, t);
    rst_n = 0;
    #2;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_ready", in_ready, 0);
    chk("mrst_data", {outdata3, outdata2, outdata1, outdata0}, 0);
    chk("mrst_count", out_count, 0);
    q.delete();
    part.delete();
    @(posedge clock); #1; rst_n = 1;
    @(posedge clock); #1;
    out_ready = 1;
    g0 = ngroups;
    for (int k = 0; k < 4; k++) send(8'(40 + k), 0, t);
    drain();
    chk("mrst_groups", ngroups - g0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/order_gather_4.md
Name: order_gather_4

Overview:
- Upstream feeder for the 4-input sorter order_1_4.
- Accepts a serial word stream under valid/ready and packs it into groups of 4 parallel words.
- Presents each group on outdata0..outdata3 with a valid/ready handshake.
- A partial group closed by in_last is padded with PAD so the sorter pushes padding to the high end.

Parameters:
- DSIZE, 8: width of each data word.
- PAD, {DSIZE{1'b1}} (all ones): fill value for unused slots of a partial group.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  DSIZE  serial input word.
- in_last  input  1  closes the current group after this word (end of frame).
- out_valid  output  1  group on outdata0..3 valid.
- out_ready  input  1  downstream accepts the group.
- outdata0  output  DSIZE  first word of the group, in arrival order.
- outdata1  output  DSIZE  second word of the group, or PAD.
- outdata2  output  DSIZE  third word of the group, or PAD.
- outdata3  output  DSIZE  fourth word of the group, or PAD.
- out_count  output  3  number of real words in the group, 1..4.
- out_last  output  1  group was closed by in_last.

Behaviour:
- Reset state (rst_n low, asynchronous):
  - out_valid=0, outdata0..3=0, out_count=0, out_last=0.
  - Collect index=0, collect buffer cleared, pending=0.
  - in_ready=0 while rst_n is low.
- Accept: a word is accepted on a rising edge with in_valid && in_ready. It is written to collect slot [index], and index increments.
- Closing word: the accepted word is closing if index==3 or in_last==1.
  - On a closing accept, unused slots take PAD; count=index+1; last=in_last. index returns to 0.
- Output register is "free" when !out_valid || out_ready at that edge.
  - Closing accept with output free: the group loads into the output registers at that same edge, so out_valid rises the cycle after the 4th (or last) word is accepted. Latency is 1 cycle.
  - Closing accept with output not free: the group is held in the collect buffer and pending=1.
- Pending:
  - While pending=1, in_ready=0. in_ready = !pending && rst_n; it is a combinational function of state only and never depends on in_valid.
  - At the first edge where the output is free, the pending group moves to the output registers and pending=0. in_ready returns high in the next cycle.
- Output handshake:
  - The group is consumed on an edge with out_valid && out_ready.
  - outdata*, out_count and out_last stay stable while out_valid && !out_ready.
  - If no new group loads at a consuming edge, out_valid drops to 0.
  - Consume and load at the same edge: the new group replaces the old one and out_valid stays 1.
- Throughput: with out_ready held at 1, the block accepts 1 word per cycle indefinitely with no bubbles and emits 1 group per 4 words.
- in_last on the first word gives count=1 with outdata1..3=PAD.
- in_last on the 4th word gives count=4 with out_last=1.
- in_last while in_valid=0 is ignored.
- Reset mid-group: partial collected words are discarded, no output is produced for them, and an active out_valid drops immediately.
- out_count, out_last and outdata* are registered outputs; there is no combinational path from in_* to out_*.

Test Plan:
- Full group: words 3,7,1,9 on consecutive cycles, out_ready=1 → next cycle out_valid=1, outdata0..3=3,7,1,9, out_count=4, out_last=0, for one cycle.
- Partial flush: 5, then 2 with in_last=1 → outdata0..3=5,2,255,255, out_count=2, out_last=1.
- Backpressure: out_ready=0, send 8 words → group 1 held stable; after word 8, in_ready=0. Raise out_ready for 1 cycle → group 2 appears, in_ready returns to 1 the cycle after the transfer, and no words are lost or duplicated.
- Streaming: 40 random words in 0..10 with out_ready=1 and in_valid always high → in_ready never drops, 10 groups emitted, scoreboard matches arrival order.
- Reset mid-group: accept 2 words, pulse rst_n low → outputs return to reset values, in_ready=0 during reset. Then send 4 new words → single group containing only the new words, count=4.
- Single-word frame: in_last on the first word → outdata0=word, outdata1..3=PAD, out_count=1, out_last=1.
